mpe_ctrl: RTL

Sequencer that drives one `mpe` crossover/mutation PE for a batch of parent-gene pairs.
- Loads the PE's setup word (parent fitnesses, mutation probabilities, child genome id) once per batch.
- Fetches gene pairs from an upstream valid/ready stream and holds each pair and its random word stable through the PE's two-stage pipeline.
- Captures the resulting child gene and emits it on a downstream valid/ready stream.
- Sits between the gene buffer / random source and the `mpe` datapath.

---
 rtl/mpe_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mpe_ctrl.sv
// mpe_ctrl: batch sequencer feeding one mpe crossover/mutation PE.
// Define MPE_CTRL_PERF_EN to add a saturating busy-cycle counter.
module mpe_ctrl #(
  parameter int WORD_SZ = 64,
  parameter int GENE_SZ = 64,
  parameter int CNT_SZ  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [WORD_SZ-1:0] cfg_word,
  input  logic [7:0]         cfg_id,
  input  logic [CNT_SZ-1:0]  num_pairs,
  input  logic               pair_valid,
  output logic               pair_ready,
  input  logic [GENE_SZ-1:0] pair_gene1,
  input  logic [GENE_SZ-1:0] pair_gene2,
  input  logic [WORD_SZ-1:0] rnd_in,
  output logic               rnd_req,
  output logic               mpe_setup,
  output logic [WORD_SZ-1:0] mpe_data1,
  output logic [WORD_SZ-1:0] mpe_data2,
  output logic [WORD_SZ-1:0] mpe_rnd,
  input  logic [GENE_SZ-1:0] mpe_child,
  output logic               child_valid,
  input  logic               child_ready,
  output logic [GENE_SZ-1:0] child_gene,
  output logic               busy,
  output logic               done,
  output logic [CNT_SZ-1:0]  child_cnt,
  output logic [31:0]        perf_cycles
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_FETCH, S_HOLD,
    S_CAPT, S_OUT, S_DONE
  } state_t;

  state_t             r_state, w_next;
  logic [1:0]         r_hold;
  logic [CNT_SZ-1:0]  r_num, r_cnt, w_cnt_inc;
  logic [WORD_SZ-1:0] r_cfg_word, r_d1, r_d2, r_rnd;
  logic [7:0]         r_cfg_id;
  logic [GENE_SZ-1:0] r_child;
  logic               r_zdone;
  logic               w_go, w_zero, w_fire, w_take;

  assign w_go      = (r_state == S_IDLE) && start && !abort
                     && (num_pairs != '0);
  assign w_zero    = (r_state == S_IDLE) && start && !abort
                     && (num_pairs == '0);
  assign w_fire    = pair_valid && pair_ready;
  assign w_take    = child_valid && child_ready;
  assign w_cnt_inc = r_cnt + CNT_SZ'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    pair_ready  = 1'b0;
    mpe_setup   = 1'b0;
    child_valid = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_go) w_next = S_SETUP;
      S_SETUP: begin
        mpe_setup = 1'b1;
        w_next    = S_FETCH;
      end
      S_FETCH: begin
        pair_ready = !abort;
        if (pair_valid) w_next = S_HOLD;
      end
      S_HOLD:  if (r_hold == 2'd2) w_next = S_CAPT;
      S_CAPT:  w_next = S_OUT;
      S_OUT: begin
        child_valid = !abort;
        if (child_ready)
          w_next = (w_cnt_inc == r_num) ? S_DONE : S_FETCH;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // abort wins over every other transition
    if (abort && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold     <= '0;
      r_num      <= '0;
      r_cnt      <= '0;
      r_cfg_word <= '0;
      r_cfg_id   <= '0;
      r_d1       <= '0;
      r_d2       <= '0;
      r_rnd      <= '0;
      r_child    <= '0;
      r_zdone    <= 1'b0;
    end else begin
      r_zdone <= w_zero;
      r_hold  <= (r_state == S_HOLD) ? r_hold + 2'd1 : 2'd0;
      if (w_go) begin
        r_num      <= num_pairs;
        r_cfg_word <= cfg_word;
        r_cfg_id   <= cfg_id;
        r_cnt      <= '0;
      end
      if (w_fire) begin
        r_d1  <= WORD_SZ'(pair_gene1);
        r_d2  <= WORD_SZ'(pair_gene2);
        r_rnd <= rnd_in;
      end
      if (r_state == S_CAPT) r_child <= mpe_child;
      if (w_take) r_cnt <= w_cnt_inc;
    end
  end

  // cfg is muxed in only during SETUP so the last pair survives it
  assign mpe_data1  = mpe_setup ? r_cfg_word : r_d1;
  assign mpe_data2  = mpe_setup ? {{(WORD_SZ-8){1'b0}}, r_cfg_id}
                                : r_d2;
  assign mpe_rnd    = r_rnd;
  assign rnd_req    = w_fire;
  assign child_gene = r_child;
  assign child_cnt  = r_cnt;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE) || r_zdone;

`ifdef MPE_CTRL_PERF_EN
  logic [31:0] r_perf;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      r_perf <= '0;
    else if (w_go)                 r_perf <= '0;
    else if (busy && r_perf != '1) r_perf <= r_perf + 32'd1;
  end
  assign perf_cycles = r_perf;
`else
  assign perf_cycles = '0;
`endif

endmodule
